// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card read path: arbiter sequencing states, block size
// and SPI-mode command constants used by the SD interface block.
package sd_pkg;

  typedef enum logic [2:0] {
    StWaitInit,
    StArb,
    StIssue,
    StStream,
    StDrain,
    StError
  } state_e;

  localparam int unsigned BlockBytes = 512;

  localparam logic [5:0] CmdGoIdle       = 6'd0;
  localparam logic [5:0] CmdSendIfCond   = 6'd8;
  localparam logic [5:0] CmdSetBlockLen  = 6'd16;
  localparam logic [5:0] CmdReadSingle   = 6'd17;
  localparam logic [7:0] TokenStartBlock = 8'hFE;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned PtrW   = (NumReq > 2) ? 2 : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    // Scan offsets from the pointer outward; the first hit wins.
    for (int unsigned k = 0; k < NumReq; k++) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (!found && req_i[i] && (i == (32'(ptr_i) + k) % NumReq)) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sd_read_arbiter.sv
// Shares one SD read engine between NUM_REQ sector readers: round-robin grant, one block
// per grant, bytes forwarded with an index, watchdog error if a read stalls.
module sd_read_arbiter
  import sd_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_SHIFT  = 9,
  parameter int unsigned TIMEOUT     = 2000000,
  parameter int unsigned BLOCK_BYTES = BlockBytes
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_sector,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  rd_strobe,
  output logic [7:0]            rd_data,
  output logic [8:0]            rd_index,
  output logic [NUM_REQ-1:0]    done,
  output logic [NUM_REQ-1:0]    err,
  input  logic                  sd_idle,
  input  logic                  sd_byte_ready,
  input  logic                  sd_data_phase,
  input  logic [7:0]            sd_byte,
  output logic                  sd_begin_read,
  output logic [31:0]           sd_addr
);

  localparam int unsigned PtrW = (NUM_REQ > 2) ? 2 : 1;
  localparam int unsigned CntW = $clog2(BLOCK_BYTES);

  state_e             state_q, state_d;
  logic [PtrW-1:0]    ptr_q, ptr_d, owner_next;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d, err_q, err_d, rr_gnt;
  logic [31:0]        addr_q, addr_d, tmo_q, tmo_d, sel_sector;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic [8:0]         index_q, index_d;
  logic               strobe_q, strobe_d, begin_q, begin_d;
  logic               timed_out;

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .PtrW   (PtrW)
  ) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  always_comb begin
    sel_sector = '0;
    owner_next = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rr_gnt[i]) sel_sector = req_sector[32*i +: 32];
      if (grant_q[i]) owner_next = (i == NUM_REQ - 1) ? '0 : PtrW'(i + 1);
    end
  end

  assign timed_out = (tmo_q == TIMEOUT - 1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    index_d  = index_q;
    strobe_d = 1'b0;
    begin_d  = 1'b0;
    done_d   = '0;
    err_d    = '0;

    unique case (state_q)
      StWaitInit: if (sd_idle) state_d = StArb;
      StArb: begin
        if (|req) begin
          grant_d = rr_gnt;
          addr_d  = sel_sector << ADDR_SHIFT;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (sd_idle) begin
          begin_d = 1'b1;
          tmo_d   = '0;
          cnt_d   = '0;
          state_d = StStream;
        end
      end
      StStream, StDrain: begin
        tmo_d = tmo_q + 32'd1;
        // Watchdog has priority over both byte forwarding and completion.
        if (timed_out) begin
          err_d   = grant_q;
          grant_d = '0;
          ptr_d   = owner_next;
          state_d = StError;
        end else if (state_q == StStream) begin
          if (sd_byte_ready && sd_data_phase) begin
            strobe_d = 1'b1;
            data_d   = sd_byte;
            index_d  = 9'(cnt_q);
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntW'(BLOCK_BYTES - 1)) state_d = StDrain;
          end
        end else if (sd_idle) begin
          done_d  = grant_q;
          grant_d = '0;
          ptr_d   = owner_next;
          state_d = StArb;
        end
      end
      StError: if (sd_idle) state_d = StArb;
      default: state_d = StWaitInit;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StWaitInit;
      ptr_q    <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      index_q  <= '0;
      strobe_q <= 1'b0;
      begin_q  <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      index_q  <= index_d;
      strobe_q <= strobe_d;
      begin_q  <= begin_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign grant         = grant_q;
  assign rd_strobe     = strobe_q;
  assign rd_data       = data_q;
  assign rd_index      = index_q;
  assign done          = done_q;
  assign err           = err_q;
  assign sd_begin_read = begin_q;
  assign sd_addr       = addr_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Bench for sd_read_arbiter: behavioural SD engine, byte scoreboard, arbitration vector table
// and hand-written timeout, request-drop and mid-transfer reset sequences.
module tb_sd_read_arbiter;

  localparam int unsigned NumReq  = 2;
  localparam int unsigned Timeout = 1000;

  typedef struct packed {
    logic [7:0] data;
    logic [8:0] idx;
  } sb_t;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] sec0;
    logic [31:0] sec1;
    logic [1:0]  g0;
    logic [31:0] a0;
    logic [1:0]  g1;
    logic [31:0] a1;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [63:0] req_sector;
  logic [1:0]  grant, done, err;
  logic        rd_strobe, sd_begin_read;
  logic [7:0]  rd_data;
  logic [8:0]  rd_index;
  logic [31:0] sd_addr;
  logic        sd_idle, sd_byte_ready, sd_data_phase;
  logic [7:0]  sd_byte;
  logic        eng_ready, hold_idle, abort;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cyc_begin = 0;
  int nbegin = 0;
  int nstrobe = 0;
  int stall_after = 10000;
  sb_t sb[$];
  vec_t vecs[4];

  assign sd_idle = eng_ready & ~hold_idle;

  always #5 clock = ~clock;

  sd_read_arbiter #(
    .NUM_REQ    (NumReq),
    .ADDR_SHIFT (9),
    .TIMEOUT    (Timeout),
    .BLOCK_BYTES(512)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_sector   (req_sector),
    .grant        (grant),
    .rd_strobe    (rd_strobe),
    .rd_data      (rd_data),
    .rd_index     (rd_index),
    .done         (done),
    .err          (err),
    .sd_idle      (sd_idle),
    .sd_byte_ready(sd_byte_ready),
    .sd_data_phase(sd_data_phase),
    .sd_byte      (sd_byte),
    .sd_begin_read(sd_begin_read),
    .sd_addr      (sd_addr)
  );

  // ---------------- SD engine model ----------------
  task automatic eng_step(input logic rdy, input logic ph, input logic [7:0] b, output bit stop);
    sd_byte_ready = rdy;
    sd_data_phase = ph;
    sd_byte       = b;
    @(posedge clock);
    #1;
    stop = abort;
  endtask

  task automatic run_xfer();
    bit stop;
    int j;
    sb_t e;
    logic [7:0] b;
    stop = 1'b0;
    eng_ready = 1'b0;
    // Command/response bytes outside the payload phase.
    for (int i = 0; i < 6; i++) if (!stop) eng_step(1'b1, 1'b0, 8'hF0 + 8'(i), stop);
    if (!stop) eng_step(1'b0, 1'b0, 8'h00, stop);
    j = 0;
    while (!stop && j < 514) begin
      if (j == stall_after) begin
        sd_byte_ready = 1'b0;
        repeat (1200) @(posedge clock);
        #1;
        stop = 1'b1;
      end else begin
        b = 8'($urandom);
        if (j < 512) begin
          e.data = b;
          e.idx  = 9'(j);
          sb.push_back(e);
        end
        eng_step(1'b1, 1'b1, b, stop);
        if (!stop && (j % 128) == 127) eng_step(1'b0, 1'b1, 8'h00, stop);
        j++;
      end
    end
    if (!stop) eng_step(1'b1, 1'b0, 8'h5A, stop);
    if (!stop) eng_step(1'b1, 1'b0, 8'hC3, stop);
    if (!stop) eng_step(1'b0, 1'b0, 8'h00, stop);
    sd_byte_ready = 1'b0;
    sd_data_phase = 1'b0;
    eng_ready     = 1'b1;
  endtask

  initial begin
    eng_ready     = 1'b1;
    sd_byte_ready = 1'b0;
    sd_data_phase = 1'b0;
    sd_byte       = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      if (sd_begin_read === 1'b1 && !reset) run_xfer();
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(negedge clock);
    cyc++;
    if (sd_begin_read) begin
      nbegin++;
      cyc_begin = cyc;
    end
    if (rd_strobe) begin
      nstrobe++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_strobe_unexpected: got index %0d expected no strobe", rd_index);
      end else begin
        e = sb.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.data));
        chk("rd_index", 32'(rd_index), 32'(e.idx));
      end
    end
    if (done != '0) chk("strobe_with_done", 32'(rd_strobe), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_strobe_done_err_begin"}, {28'd0, rd_strobe, sd_begin_read, |done, |err}, 32'd0);
    chk({tag, "_rd_data_index"}, {15'd0, rd_data, rd_index}, 32'd0);
    chk({tag, "_sd_addr"}, sd_addr, 32'd0);
  endtask

  task automatic serve(input int who, input logic [31:0] exp_addr, input int drop_at,
                       input bit exp_err, input bit chk_lat);
    int n;
    int s0;
    bit got;
    logic [1:0] mask;
    mask = 2'(1 << who);
    n = 0;
    while (grant == '0 && n < 3000) begin
      tick();
      n++;
    end
    if (chk_lat) chk("grant_latency", 32'(n), 32'd1);
    chk("grant", 32'(grant), 32'(mask));
    chk("sd_addr", sd_addr, exp_addr);
    s0  = nstrobe;
    got = 1'b0;
    n   = 0;
    while (!got && n < 5000) begin
      tick();
      n++;
      if (drop_at >= 0 && rd_strobe && rd_index == 9'(drop_at)) req[who] = 1'b0;
      if (done != '0 || err != '0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL end_of_transfer: got no done/err expected one within 5000 cycles");
    end else if (exp_err) begin
      chk("err", 32'(err), 32'(mask));
      chk("done_on_err", 32'(done), 32'd0);
      chk("grant_after_err", 32'(grant), 32'd0);
      chk("err_cycle", 32'(cyc - cyc_begin), Timeout);
      chk("strobes_before_err", 32'(nstrobe - s0), 32'd101);
    end else begin
      chk("done", 32'(done), 32'(mask));
      chk("err_on_done", 32'(err), 32'd0);
      chk("strobe_count", 32'(nstrobe - s0), 32'd512);
    end
    req[who] = 1'b0;
  endtask

  function automatic int owner_of(input logic [1:0] g);
    return (g == 2'b10) ? 1 : 0;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int b0;
    int n;
    bit hit;

    vecs[0] = '{req: 2'b10, sec0: 32'd0, sec1: 32'd5,
                g0: 2'b10, a0: 32'h0000_0A00, g1: 2'b00, a1: 32'd0};
    vecs[1] = '{req: 2'b11, sec0: 32'h10, sec1: 32'h20,
                g0: 2'b01, a0: 32'h0000_2000, g1: 2'b10, a1: 32'h0000_4000};
    vecs[2] = '{req: 2'b01, sec0: 32'h0080_0001, sec1: 32'd0,
                g0: 2'b01, a0: 32'h0000_0200, g1: 2'b00, a1: 32'd0};
    vecs[3] = '{req: 2'b11, sec0: 32'd1, sec1: 32'd2,
                g0: 2'b10, a0: 32'h0000_0400, g1: 2'b01, a1: 32'h0000_0200};

    reset      = 1'b1;
    req        = '0;
    req_sector = '0;
    hold_idle  = 1'b1;
    abort      = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Card not ready: request must wait, not be dropped.
    req[0]            = 1'b1;
    req_sector[31:0]  = 32'd3;
    repeat (50) tick();
    chk("init_no_begin", 32'(nbegin), 32'd0);
    chk("init_no_grant", 32'(grant), 32'd0);
    b0        = nbegin;
    hold_idle = 1'b0;
    serve(0, 32'h0000_0600, -1, 1'b0, 1'b0);
    chk("single_begin_pulse", 32'(nbegin - b0), 32'd1);

    for (int v = 0; v < 4; v++) begin
      req_sector = {vecs[v].sec1, vecs[v].sec0};
      req        = vecs[v].req;
      serve(owner_of(vecs[v].g0), vecs[v].a0, -1, 1'b0, 1'b1);
      if (vecs[v].g1 != 2'b00) serve(owner_of(vecs[v].g1), vecs[v].a1, -1, 1'b0, 1'b1);
    end

    // Engine stalls after byte 100: watchdog error, then normal service resumes.
    stall_after      = 101;
    req_sector[31:0] = 32'd9;
    req[0]           = 1'b1;
    serve(0, 32'h0000_1200, -1, 1'b1, 1'b0);
    stall_after      = 10000;
    req_sector[31:0] = 32'h11;
    req[0]           = 1'b1;
    serve(0, 32'h0000_2200, -1, 1'b0, 1'b0);

    // Requester withdraws mid-transfer; the block still completes.
    req_sector[63:32] = 32'h33;
    req[1]            = 1'b1;
    serve(1, 32'h0000_6600, 200, 1'b0, 1'b0);

    // Reset in the middle of a block.
    req_sector[63:32] = 32'd7;
    req[1]            = 1'b1;
    n = 0;
    while (grant == '0 && n < 3000) begin
      tick();
      n++;
    end
    chk("pre_reset_grant", 32'(grant), 32'd2);
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 3000) begin
      tick();
      n++;
      if (rd_strobe && rd_index == 9'd300) hit = 1'b1;
    end
    chk("reset_point_reached", 32'(hit), 32'd1);
    hold_idle = 1'b1;
    reset     = 1'b1;
    abort     = 1'b1;
    tick();
    sb.delete();
    chk_reset_outputs("midreset");
    reset = 1'b0;
    b0    = nbegin;
    repeat (20) tick();
    chk("wait_init_grant", 32'(grant), 32'd0);
    chk("wait_init_begin", 32'(nbegin - b0), 32'd0);
    abort     = 1'b0;
    hold_idle = 1'b0;
    serve(1, 32'h0000_0E00, -1, 1'b0, 1'b0);

    repeat (5) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
